// File: rtl/ysyx_23060337_pipe_buf_pkg.sv
// Shared constants and helpers for the NPC elastic pipeline buffers.
// Stage payload widths live here so every stage instance agrees on them.
package ysyx_23060337_pipe_buf_pkg;

    localparam int XLEN    = 32;
    localparam int IF_ID_W = 2 * XLEN;
    localparam int ID_EX_W = 4 * XLEN + 16;
    localparam int EX_LS_W = 3 * XLEN + 8;

    // Pointer width: at least one bit, even for a single-entry buffer.
    function automatic int ptr_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    // Occupancy counter width covering 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ysyx_23060337_pipe_buf_wrap_ctr.sv
// Modulo-DEPTH pointer counter with synchronous reset and clear.
// DEPTH need not be a power of two; the wrap is an explicit compare.
module ysyx_23060337_wrap_ctr
    import ysyx_23060337_pipe_buf_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = ptr_width(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] LAST = W'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            value <= '0;
        end else if (inc) begin
            value <= (value == LAST) ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_23060337_pipe_buf.sv
// Elastic pipeline register: DEPTH-entry FIFO with valid/ready on both sides.
// in_ready/out_valid come only from the registered count, so no ready path crosses stages.
module ysyx_23060337_pipe_buf
    import ysyx_23060337_pipe_buf_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic [count_width(DEPTH)-1:0]    count
);

    localparam int               PW   = ptr_width(DEPTH);
    localparam int               CW   = count_width(DEPTH);
    localparam logic [CW-1:0]    FULL = CW'(DEPTH);

    // Handshake: a word moves when valid and ready are both high at a posedge.
    logic          push;
    logic          pop;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : RESET_VAL;

    ysyx_23060337_wrap_ctr #(
        .DEPTH (DEPTH),
        .W     (PW)
    ) u_wr_ctr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (push),
        .value (wr_ptr)
    );

    ysyx_23060337_wrap_ctr #(
        .DEPTH (DEPTH),
        .W     (PW)
    ) u_rd_ctr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (pop),
        .value (rd_ptr)
    );

    // Flush shares the reset path so a redirect leaves no stale payload behind.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060337_pipe_buf.sv
// Directed bench for the elastic pipeline buffer at DEPTH 2, 3 and 1.
module tb_ysyx_23060337_pipe_buf;

    logic clk;
    logic rst;
    logic flush;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_count;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_count;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [31:0] c_in_data, c_out_data;
    logic [0:0]  c_count;

    localparam logic [31:0] RV_B = 32'hDEAD_BEEF;
    localparam logic [31:0] RV_C = 32'h0000_005A;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q3[$];
    logic [31:0] exp_q1[$];

    ysyx_23060337_pipe_buf #(.WIDTH(32), .DEPTH(2), .RESET_VAL(32'h0)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count)
    );

    ysyx_23060337_pipe_buf #(.WIDTH(32), .DEPTH(3), .RESET_VAL(RV_B)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count)
    );

    ysyx_23060337_pipe_buf #(.WIDTH(32), .DEPTH(1), .RESET_VAL(RV_C)) u_d1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .count(c_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one posedge and settle away from the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_head;
        logic        m_ready, m_valid, m_push, m_pop;

        rst = 1'b1; flush = 1'b0;
        a_in_valid = 1'b1; a_in_data = 32'h1111_1111; a_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_data = 32'h2222_2222; b_out_ready = 1'b0;
        c_in_valid = 1'b1; c_in_data = 32'h3333_3333; c_out_ready = 1'b0;

        // Reset held two cycles with upstream offering data.
        tick();
        tick();
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_out_data", a_out_data, 32'h0);
        chk("rst_out_data_d3", b_out_data, RV_B);
        chk("rst_out_data_d1", c_out_data, RV_C);
        rst = 1'b0;
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        tick();
        chk("rst_no_push", 32'(a_count), 32'd0);

        // Fill then drain.
        a_in_valid = 1'b1; a_in_data = 32'hA1;
        tick();
        chk("fill1_count", 32'(a_count), 32'd1);
        chk("fill1_out_data", a_out_data, 32'hA1);
        chk("fill1_out_valid", 32'(a_out_valid), 32'd1);
        a_in_data = 32'hB2;
        tick();
        chk("fill2_count", 32'(a_count), 32'd2);
        chk("fill2_in_ready", 32'(a_in_ready), 32'd0);
        chk("fill2_out_data", a_out_data, 32'hA1);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        tick();
        chk("drain1_count", 32'(a_count), 32'd1);
        chk("drain1_out_data", a_out_data, 32'hB2);
        tick();
        chk("drain2_count", 32'(a_count), 32'd0);
        chk("drain2_out_valid", 32'(a_out_valid), 32'd0);
        chk("drain2_out_data", a_out_data, 32'h0);

        // Streaming at one word per cycle.
        a_in_valid = 1'b1; a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_in_data = 32'(i);
            tick();
            chk($sformatf("stream%0d_out_data", i), a_out_data, 32'(i));
            chk($sformatf("stream%0d_count", i), 32'(a_count), 32'd1);
        end
        a_in_valid = 1'b0;
        tick();
        chk("stream_end_count", 32'(a_count), 32'd0);

        // Full with simultaneous pop: push must be refused.
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h10;
        tick();
        a_in_data = 32'h11;
        tick();
        chk("full_count", 32'(a_count), 32'd2);
        a_in_data = 32'hC3; a_out_ready = 1'b1;
        chk("full_in_ready", 32'(a_in_ready), 32'd0);
        tick();
        chk("fullpop_count", 32'(a_count), 32'd1);
        chk("fullpop_out_data", a_out_data, 32'h11);
        chk("fullpop_in_ready", 32'(a_in_ready), 32'd1);
        tick();
        chk("retry_count", 32'(a_count), 32'd1);
        chk("retry_out_data", a_out_data, 32'hC3);
        a_in_valid = 1'b0;
        tick();
        chk("retry_drain_count", 32'(a_count), 32'd0);

        // Flush beats push and pop in the same cycle.
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h21;
        tick();
        a_in_data = 32'h22;
        tick();
        chk("preflush_count", 32'(a_count), 32'd2);
        flush = 1'b1; a_in_data = 32'h99; a_out_ready = 1'b1;
        tick();
        flush = 1'b0; a_in_valid = 1'b0;
        chk("flush_count", 32'(a_count), 32'd0);
        chk("flush_out_valid", 32'(a_out_valid), 32'd0);
        chk("flush_out_data", a_out_data, 32'h0);
        chk("flush_in_ready", 32'(a_in_ready), 32'd1);
        chk("flush_out_data_d3", b_out_data, RV_B);
        tick();
        chk("postflush_count", 32'(a_count), 32'd0);
        a_in_valid = 1'b1; a_in_data = 32'h77; a_out_ready = 1'b0;
        tick();
        a_in_valid = 1'b0;
        chk("postflush_push", a_out_data, 32'h77);
        chk("postflush_push_count", 32'(a_count), 32'd1);

        // DEPTH=3 and DEPTH=1 against a queue scoreboard; a directed prefix forces the wrap.
        exp_q3.delete();
        exp_q1.delete();
        for (int i = 0; i < 30; i++) begin
            if (i < 3) begin
                b_in_valid = 1'b1; b_out_ready = 1'b0;
            end else if (i < 6) begin
                b_in_valid = 1'b0; b_out_ready = 1'b1;
            end else begin
                b_in_valid  = ($urandom_range(0, 3) != 0);
                b_out_ready = ($urandom_range(0, 2) != 0);
            end
            b_in_data   = 32'h300 + 32'(i);
            c_in_valid  = ($urandom_range(0, 3) != 0);
            c_out_ready = ($urandom_range(0, 1) != 0);
            c_in_data   = 32'h100 + 32'(i);
            #1;

            m_ready  = (exp_q3.size() < 3);
            m_valid  = (exp_q3.size() != 0);
            exp_head = m_valid ? exp_q3[0] : RV_B;
            chk($sformatf("d3_in_ready_%0d", i), 32'(b_in_ready), 32'(m_ready));
            chk($sformatf("d3_out_valid_%0d", i), 32'(b_out_valid), 32'(m_valid));
            chk($sformatf("d3_out_data_%0d", i), b_out_data, exp_head);
            m_push = b_in_valid && m_ready;
            m_pop  = b_out_ready && m_valid;
            if (m_pop) void'(exp_q3.pop_front());
            if (m_push) exp_q3.push_back(b_in_data);

            m_ready  = (exp_q1.size() < 1);
            m_valid  = (exp_q1.size() != 0);
            exp_head = m_valid ? exp_q1[0] : RV_C;
            chk($sformatf("d1_in_ready_%0d", i), 32'(c_in_ready), 32'(m_ready));
            chk($sformatf("d1_out_valid_%0d", i), 32'(c_out_valid), 32'(m_valid));
            chk($sformatf("d1_out_data_%0d", i), c_out_data, exp_head);
            m_push = c_in_valid && m_ready;
            m_pop  = c_out_ready && m_valid;
            if (m_pop) void'(exp_q1.pop_front());
            if (m_push) exp_q1.push_back(c_in_data);

            tick();
            chk($sformatf("d3_count_%0d", i), 32'(b_count), 32'(exp_q3.size()));
            chk($sformatf("d1_count_%0d", i), 32'(c_count), 32'(exp_q1.size()));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
